// File: rtl/hack_pkg.sv
// Shared widths and types for the Hack memory hierarchy.
package hack_pkg;
   localparam int WORD_W      = 16;
   localparam int RAM8_ADDR_W = 3;

   typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/dmux8way.sv
// 1-to-8 one-hot demux built as a tree of 1-to-2 demux stages.
module dmux8way (
   input  logic       in,
   input  logic [2:0] sel,
   output logic       o0,
   output logic       o1,
   output logic       o2,
   output logic       o3,
   output logic       o4,
   output logic       o5,
   output logic       o6,
   output logic       o7
);
   logic l1_lo, l1_hi;
   logic l2_0, l2_1, l2_2, l2_3;

   // Tree root splits on the MSB so each leaf pair differs only in sel[0].
   assign l1_lo = in & ~sel[2];
   assign l1_hi = in &  sel[2];

   assign l2_0 = l1_lo & ~sel[1];
   assign l2_1 = l1_lo &  sel[1];
   assign l2_2 = l1_hi & ~sel[1];
   assign l2_3 = l1_hi &  sel[1];

   assign o0 = l2_0 & ~sel[0];
   assign o1 = l2_0 &  sel[0];
   assign o2 = l2_1 & ~sel[0];
   assign o3 = l2_1 &  sel[0];
   assign o4 = l2_2 & ~sel[0];
   assign o5 = l2_2 &  sel[0];
   assign o6 = l2_3 & ~sel[0];
   assign o7 = l2_3 &  sel[0];
endmodule

// File: rtl/ram8_bank.sv
// 8-word register bank with per-word written-since-reset flags.
module ram8_bank
   import hack_pkg::*;
#(
   parameter int WIDTH  = WORD_W,
   parameter int ADDR_W = RAM8_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   output logic [WIDTH-1:0]  out,
   output logic              out_valid
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] flag;
   logic [DEPTH-1:0] we;

   dmux8way u_we_dmux (
      .in  (load),
      .sel (address),
      .o0  (we[0]),
      .o1  (we[1]),
      .o2  (we[2]),
      .o3  (we[3]),
      .o4  (we[4]),
      .o5  (we[5]),
      .o6  (we[6]),
      .o7  (we[7])
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         flag <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (we[i]) begin
               mem[i]  <= in;
               flag[i] <= 1'b1;
            end
         end
      end
   end

   // No write-through: the read shows the stored word until the edge.
   assign out       = mem[address];
   assign out_valid = flag[address];
endmodule

// File: tb/tb_ram8_bank.sv
// Directed self-checking bench for ram8_bank.
module tb_ram8_bank;
   logic        clk;
   logic        rst_n;
   logic [15:0] in;
   logic        load;
   logic [2:0]  address;
   logic [15:0] out;
   logic        out_valid;

   int tests;
   int fails;

   logic [15:0] exp_w [8];
   logic        exp_v [8];

   ram8_bank dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in),
      .load      (load),
      .address   (address),
      .out       (out),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n) begin
         assert (!$isunknown({load, address}))
            else $error("illegal X/Z on load/address");
      end
   end

   task automatic test_reset();
      rst_n   = 1'b0;
      load    = 1'b1;
      in      = 16'hFFFF;
      address = 3'd0;
      #1;
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1;
         tests++;
         if (out !== 16'h0000 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_read[%0d]: got %h/%b want 0000/0",
                     i, out, out_valid);
         end
      end
      for (int e = 0; e < 3; e++) begin
         @(negedge clk);
         address = 3'(e * 3);
         @(posedge clk);
         #1;
         tests++;
         if (out !== 16'h0000 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_load[%0d]: got %h/%b want 0000/0",
                     e, out, out_valid);
         end
      end
      @(negedge clk);
      load  = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_w[i] = 16'h0000;
         exp_v[i] = 1'b0;
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         address = 3'(i);
         in      = 16'h1000 + 16'(i);
         load    = 1'b1;
         @(posedge clk);
         #1;
         tests++;
         if (out !== 16'h1000 + 16'(i) || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL fill_write[%0d]: got %h/%b want %h/1",
                     i, out, out_valid, 16'h1000 + 16'(i));
         end
         exp_w[i] = 16'h1000 + 16'(i);
         exp_v[i] = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1;
         tests++;
         if (out !== 16'h1000 + 16'(i) || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL fill_read[%0d]: got %h/%b want %h/1",
                     i, out, out_valid, 16'h1000 + 16'(i));
         end
      end
   endtask

   task automatic test_raw();
      @(negedge clk);
      address = 3'd5;
      in      = 16'hBEEF;
      load    = 1'b1;
      #1;
      tests++;
      if (out !== 16'h1005) begin
         fails++;
         $display("FAIL raw_before: got %h want 1005", out);
      end
      @(posedge clk);
      #1;
      tests++;
      if (out !== 16'hBEEF || out_valid !== 1'b1) begin
         fails++;
         $display("FAIL raw_after: got %h/%b want beef/1", out, out_valid);
      end
      exp_w[5] = 16'hBEEF;
      @(negedge clk);
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1;
         tests++;
         if (out !== exp_w[i] || out_valid !== exp_v[i]) begin
            fails++;
            $display("FAIL raw_others[%0d]: got %h/%b want %h/%b",
                     i, out, out_valid, exp_w[i], exp_v[i]);
         end
      end
   endtask

   task automatic test_noload();
      @(negedge clk);
      address = 3'd2;
      in      = 16'hDEAD;
      load    = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      tests++;
      if (out !== 16'h1002) begin
         fails++;
         $display("FAIL noload_word2: got %h want 1002", out);
      end
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1;
         tests++;
         if (out !== exp_w[i] || out_valid !== exp_v[i]) begin
            fails++;
            $display("FAIL noload_read[%0d]: got %h/%b want %h/%b",
                     i, out, out_valid, exp_w[i], exp_v[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      address = 3'd3;
      in      = 16'h0001;
      load    = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (out !== 16'h0001) begin
         fails++;
         $display("FAIL b2b_first: got %h want 0001", out);
      end
      in = 16'h0002;
      @(posedge clk);
      #1;
      load = 1'b0;
      tests++;
      if (out !== 16'h0002 || out_valid !== 1'b1) begin
         fails++;
         $display("FAIL b2b_last: got %h/%b want 0002/1", out, out_valid);
      end
      exp_w[3] = 16'h0002;
      address = 3'd2;
      #1;
      tests++;
      if (out !== 16'h1002) begin
         fails++;
         $display("FAIL b2b_nbr2: got %h want 1002", out);
      end
      address = 3'd4;
      #1;
      tests++;
      if (out !== 16'h1004) begin
         fails++;
         $display("FAIL b2b_nbr4: got %h want 1004", out);
      end
   endtask

   task automatic test_addr_change();
      @(negedge clk);
      address = 3'd1;
      in      = 16'h5A5A;
      load    = 1'b1;
      #2;
      address = 3'd6;
      @(posedge clk);
      #1;
      load = 1'b0;
      exp_w[6] = 16'h5A5A;
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1;
         tests++;
         if (out !== exp_w[i] || out_valid !== exp_v[i]) begin
            fails++;
            $display("FAIL addr_change[%0d]: got %h/%b want %h/%b",
                     i, out, out_valid, exp_w[i], exp_v[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      address = 3'd0;
      in      = 16'hAAAA;
      load    = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (out !== 16'h0000 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_async: got %h/%b want 0000/0",
                  out, out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      load  = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_w[i] = 16'h0000;
         exp_v[i] = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1;
         tests++;
         if (out !== 16'h0000 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_clear[%0d]: got %h/%b want 0000/0",
                     i, out, out_valid);
         end
      end
      @(negedge clk);
      address = 3'd7;
      in      = 16'h7777;
      load    = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      exp_w[7] = 16'h7777;
      exp_v[7] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1;
         tests++;
         if (out !== exp_w[i] || out_valid !== exp_v[i]) begin
            fails++;
            $display("FAIL rstmid_w7[%0d]: got %h/%b want %h/%b",
                     i, out, out_valid, exp_w[i], exp_v[i]);
         end
      end
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      rst_n   = 1'b0;
      load    = 1'b0;
      in      = 16'h0000;
      address = 3'd0;
      test_reset();
      test_fill();
      test_raw();
      test_noload();
      test_back_to_back();
      test_addr_change();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
